// File: rtl/scsi_dma_responder_if.sv
// Host-side bus of the SCSI DMA responder: register strobes, DMA handshake,
// and the read-data/interrupt/request returns.
interface scsi_dma_responder_if;
    logic       SCSI_CS;
    logic       A0;
    logic       DACK;
    logic       RE;
    logic       WE;
    logic [7:0] DIN;
    logic [7:0] DOUT;
    logic       DOE;
    logic       DREQ_;
    logic       INTRQ;

    modport slave (
        input  SCSI_CS, A0, DACK, RE, WE, DIN,
        output DOUT, DOE, DREQ_, INTRQ
    );

    modport master (
        output SCSI_CS, A0, DACK, RE, WE, DIN,
        input  DOUT, DOE, DREQ_, INTRQ
    );
endinterface

// File: rtl/scsi_dma_responder.sv
// SCSI DMA responder: 8-byte FIFO between a device port and a host bus that
// reaches it either through indexed registers or a DREQ_/DACK DMA handshake.
module scsi_dma_responder (
    input  logic                 CLK90,
    input  logic                 CRESET_,
    scsi_dma_responder_if.slave  bus,
    input  logic                 DEV_WR,
    input  logic [7:0]           DEV_WDATA,
    input  logic                 DEV_RD,
    output logic [7:0]           DEV_RDATA,
    output logic                 DEV_FULL,
    output logic                 DEV_EMPTY
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_ACK, S_HOLD, S_DONE} state_t;
    state_t state, state_nxt;

    logic [7:0]  mem [8];
    logic [2:0]  wp, rp;
    logic [3:0]  cnt;
    logic [4:0]  addr;
    logic [15:0] tc;
    logic        dmaen, dir;
    logic        st_done, st_under, st_over, st_coll, intrq;
    logic [7:0]  cap;
    logic        saw_rd, saw_wr;
    logic        reg_wr_p1, reg_rd_p1;
    logic        doe_p1;
    logic [7:0]  dout_p1;
    logic        doe_nxt;
    logic [7:0]  dout_nxt, reg_rdata;
    logic        dma_pop, dma_push, tc_dec, done_set;

    // DMA owns the bus whenever DACK is up; a concurrent chip select is a collision.
    logic dma_strobe, cs_ok, cs_coll, reg_wr_s, reg_wr_go, reg_rd_s, reg_rd_rel;
    logic dma_active, dma_rd_s, dma_wr_s, wrong_dir, start_ok;
    assign dma_strobe = bus.DACK & (bus.RE | bus.WE);
    assign cs_ok      = bus.SCSI_CS & ~bus.DACK;
    assign cs_coll    = bus.SCSI_CS & bus.DACK & (bus.RE | bus.WE);
    assign reg_wr_s   = cs_ok & bus.WE;
    assign reg_wr_go  = reg_wr_s & ~reg_wr_p1;
    assign reg_rd_s   = cs_ok & bus.RE & bus.A0;
    assign reg_rd_rel = reg_rd_p1 & ~reg_rd_s;
    assign dma_active = (state == S_REQ) || (state == S_ACK);
    assign dma_rd_s   = dma_active & bus.DACK & bus.RE;
    assign dma_wr_s   = dma_active & bus.DACK & bus.WE;
    assign wrong_dir  = dir ? dma_wr_s : dma_rd_s;
    assign start_ok   = dmaen & (tc != 16'd0) & (dir ? (cnt != 4'd0) : (cnt != 4'd8));

    logic dev_pop, dev_push, pop_req, push_req, pop_ok, push_ok, clr_status;
    logic [7:0] push_data;
    assign dev_pop    = DEV_RD & ~dma_pop;
    assign dev_push   = DEV_WR & ~dma_push;
    assign pop_req    = dma_pop | dev_pop;
    assign push_req   = dma_push | dev_push;
    assign pop_ok     = pop_req & (cnt != 4'd0);
    assign push_ok    = push_req & ((cnt != 4'd8) | pop_ok);
    assign push_data  = dma_push ? cap : DEV_WDATA;
    assign clr_status = reg_rd_rel & (addr == 5'h17);

    assign DEV_FULL  = (cnt == 4'd8);
    assign DEV_EMPTY = (cnt == 4'd0);
    assign bus.DREQ_ = (state != S_REQ);
    assign bus.INTRQ = intrq;
    assign bus.DOE   = doe_p1;
    assign bus.DOUT  = dout_p1;

    always_comb begin
        case (addr)
            5'h12:   reg_rdata = tc[15:8];
            5'h13:   reg_rdata = tc[7:0];
            5'h15:   reg_rdata = {6'b0, dir, dmaen};
            5'h17:   reg_rdata = {st_done, st_under, st_over, st_coll, 4'b0};
            default: reg_rdata = 8'h00;
        endcase
    end

    always_comb begin
        doe_nxt  = (bus.SCSI_CS | bus.DACK) & bus.RE;
        dout_nxt = 8'h00;
        if (bus.DACK & bus.RE)
            dout_nxt = (dma_active & dir & (cnt != 4'd0)) ? mem[rp] : 8'h00;
        else if (bus.SCSI_CS & bus.RE)
            dout_nxt = bus.A0 ? reg_rdata : {intrq, 6'b0, dmaen};
    end

    always_comb begin
        state_nxt = state;
        dma_pop   = 1'b0;
        dma_push  = 1'b0;
        tc_dec    = 1'b0;
        done_set  = 1'b0;
        case (state)
            S_IDLE: if (start_ok) state_nxt = S_REQ;
            S_REQ: begin
                if (!dmaen)          state_nxt = S_IDLE;
                else if (dma_strobe) state_nxt = S_ACK;
            end
            S_ACK: begin
                if (!dma_strobe) begin
                    state_nxt = S_HOLD;
                    tc_dec    = 1'b1;
                    dma_pop   = dir & saw_rd;
                    dma_push  = ~dir & saw_wr;
                end
            end
            S_HOLD: begin
                if (tc == 16'd0)   state_nxt = S_DONE;
                else if (start_ok) state_nxt = S_REQ;
                else               state_nxt = S_IDLE;
            end
            S_DONE: begin
                done_set  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p1: strobe history, bus read data and DMA strobe tracking.
    always_ff @(posedge CLK90 or negedge CRESET_) begin
        if (!CRESET_) begin
            state     <= S_IDLE;
            saw_rd    <= 1'b0;
            saw_wr    <= 1'b0;
            reg_wr_p1 <= 1'b0;
            reg_rd_p1 <= 1'b0;
            doe_p1    <= 1'b0;
            dout_p1   <= 8'h00;
        end else begin
            state     <= state_nxt;
            reg_wr_p1 <= reg_wr_s;
            reg_rd_p1 <= reg_rd_s;
            doe_p1    <= doe_nxt;
            dout_p1   <= dout_nxt;
            if (state == S_REQ) begin
                saw_rd <= dma_rd_s;
                saw_wr <= dma_wr_s;
            end else if (state == S_ACK) begin
                saw_rd <= saw_rd | dma_rd_s;
                saw_wr <= saw_wr | dma_wr_s;
            end
        end
    end

    always_ff @(posedge CLK90) begin
        if (dma_wr_s) cap <= bus.DIN;
        if (push_ok)  mem[wp] <= push_data;
    end

    always_ff @(posedge CLK90 or negedge CRESET_) begin
        if (!CRESET_) begin
            wp        <= 3'd0;
            rp        <= 3'd0;
            cnt       <= 4'd0;
            DEV_RDATA <= 8'h00;
        end else begin
            if (push_ok) wp <= wp + 3'd1;
            if (pop_ok)  rp <= rp + 3'd1;
            cnt <= cnt + {3'b0, push_ok} - {3'b0, pop_ok};
            if (dev_pop) DEV_RDATA <= pop_ok ? mem[rp] : 8'h00;
        end
    end

    // Register file; TC is frozen against host writes while a transfer is in flight.
    always_ff @(posedge CLK90 or negedge CRESET_) begin
        if (!CRESET_) begin
            addr     <= 5'd0;
            tc       <= 16'd0;
            dmaen    <= 1'b0;
            dir      <= 1'b0;
            st_done  <= 1'b0;
            st_under <= 1'b0;
            st_over  <= 1'b0;
            st_coll  <= 1'b0;
            intrq    <= 1'b0;
        end else begin
            if (reg_rd_rel) addr <= addr + 5'd1;
            if (reg_wr_go) begin
                if (!bus.A0) begin
                    addr <= bus.DIN[4:0];
                end else begin
                    addr <= addr + 5'd1;
                    case (addr)
                        5'h12: if (state == S_IDLE) tc[15:8] <= bus.DIN;
                        5'h13: if (state == S_IDLE) tc[7:0]  <= bus.DIN;
                        5'h15: begin
                            dir   <= bus.DIN[1];
                            dmaen <= bus.DIN[0];
                        end
                        default: ;
                    endcase
                end
            end
            if (tc_dec)   tc    <= tc - 16'd1;
            if (done_set) dmaen <= 1'b0;
            st_done  <= (st_done  & ~clr_status) | done_set;
            st_under <= (st_under & ~clr_status) | (pop_req & (cnt == 4'd0));
            st_over  <= (st_over  & ~clr_status) | (push_req & ~push_ok);
            st_coll  <= (st_coll  & ~clr_status) | cs_coll | wrong_dir;
            intrq    <= (intrq    & ~clr_status) | done_set;
        end
    end
endmodule
